// File: rtl/speck_pkg.sv
// Shared SPECK128/128 definitions: word geometry, rotate amounts, key-schedule
// state encoding and the rotate helpers also used by the round stage.
package speck_pkg;

  localparam int WORD           = 64;
  localparam int ALPHA          = 8;
  localparam int BETA           = 3;
  localparam int ROUNDS_128_128 = 32;
  localparam int IDX_W          = $clog2(ROUNDS_128_128);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    COMPUTE,
    FINISH
  } ks_state_e;

  function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] x, input int unsigned r);
    return (x >> r) | (x << (WORD - r));
  endfunction

  function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] x, input int unsigned r);
    return (x << r) | (x >> (WORD - r));
  endfunction

endpackage

// File: rtl/speck_key_step.sv
// One SPECK128/128 key-schedule step: (k, l, i) -> (k', l').
// Purely combinational so an unrolled schedule can chain copies of it.
module speck_key_step
  import speck_pkg::*;
(
  input  logic [WORD-1:0]  k_i,
  input  logic [WORD-1:0]  l_i,
  input  logic [IDX_W-1:0] round_i,
  output logic [WORD-1:0]  k_o,
  output logic [WORD-1:0]  l_o
);

  // The 64-bit sum wraps; the round index enters zero-extended.
  assign l_o = (k_i + ror(l_i, ALPHA)) ^ {{(WORD - IDX_W){1'b0}}, round_i};
  assign k_o = rol(k_i, BETA) ^ l_o;

endmodule

// File: rtl/speck_key_schedule.sv
// On-demand SPECK128/128 key expansion: presents k_0..k_{ROUNDS-1} one at a
// time on a valid/ready handshake, holding only the current (k, l) pair.
module speck_key_schedule
  import speck_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_128_128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*WORD-1:0] key,
  output logic [WORD-1:0]   subkey,
  output logic              subkey_valid,
  input  logic              subkey_ready,
  output logic [IDX_W-1:0]  round_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  ks_state_e        state_q, state_d;
  logic [WORD-1:0]  k_q, k_d;
  logic [WORD-1:0]  l_q, l_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic             busy_q, busy_d;
  logic [WORD-1:0]  k_next;
  logic [WORD-1:0]  l_next;

  speck_key_step u_step (
    .k_i     (k_q),
    .l_i     (l_q),
    .round_i (i_q),
    .k_o     (k_next),
    .l_o     (l_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      l_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      l_q     <= l_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
    end
  end

  // The last handshake goes to FINISH, so the counter never passes LAST_IDX.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    l_d     = l_q;
    i_d     = i_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = key[WORD-1:0];
          l_d     = key[2*WORD-1:WORD];
          i_d     = '0;
          busy_d  = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (subkey_ready) begin
          state_d = (i_q == LAST_IDX) ? FINISH : COMPUTE;
        end
      end
      COMPUTE: begin
        k_d     = k_next;
        l_d     = l_next;
        i_d     = i_q + 1'b1;
        state_d = PRESENT;
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign subkey       = k_q;
  assign round_idx    = i_q;
  assign subkey_valid = (state_q == PRESENT);
  assign done         = (state_q == FINISH);
  assign busy         = busy_q;

endmodule

// File: tb/tb_speck_key_schedule.sv
// Self-checking bench for speck_key_schedule against a plain-arithmetic
// SPECK128/128 key-expansion model, with randomized keys and back-pressure.
module tb_speck_key_schedule;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [127:0]  key;
  logic [63:0]   subkey;
  logic          subkey_valid;
  logic          subkey_ready;
  logic [4:0]    round_idx;
  logic          busy;
  logic          done;

  int errCount   = 0;
  int checkCount = 0;

  logic [63:0] expKeys [32];

  speck_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key          (key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference expansion straight from the cipher definition.
  task automatic buildModel(input logic [127:0] mk);
    logic [63:0] a, b;
    a = mk[63:0];
    b = mk[127:64];
    for (int r = 0; r < 32; r++) begin
      expKeys[r] = a;
      b = (a + ((b >> 8) | (b << 56))) ^ 64'(r);
      a = ((a << 3) | (a >> 61)) ^ b;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    subkey_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic startExpansion(input logic [127:0] mk);
    @(negedge clk);
    start = 1'b1;
    key   = mk;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    key = {$urandom, $urandom, $urandom, $urandom};
    subkey_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({subkey_valid, busy, done, round_idx, subkey} !== 72'd0) begin
      errCount++;
      $display("[TB] FAIL reset_state got v=%b b=%b d=%b idx=%0d sk=%h exp all zero",
               subkey_valid, busy, done, round_idx, subkey);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({subkey_valid, busy} !== 2'b00) begin
      errCount++;
      $display("[TB] FAIL reset_idle got v=%b b=%b exp 0 0", subkey_valid, busy);
    end
  endtask

  task automatic test_known_answer();
    logic [127:0] mk;
    mk = 128'h0f0e0d0c0b0a0908_0706050403020100;
    buildModel(mk);
    doReset();
    subkey_ready = 1'b1;
    startExpansion(mk);
    for (int r = 0; r < 32; r++) begin
      if (r == 0) begin
        checkCount++;
        if (subkey !== 64'h0706050403020100) begin
          errCount++;
          $display("[TB] FAIL kat_round0 got=%h exp=0706050403020100", subkey);
        end
      end
      if (r == 1) begin
        checkCount++;
        if (subkey !== 64'h37253b31171d0309) begin
          errCount++;
          $display("[TB] FAIL kat_round1 got=%h exp=37253b31171d0309", subkey);
        end
      end
      checkCount++;
      if ({subkey_valid, busy, done, round_idx, subkey} !== {3'b110, 5'(r), expKeys[r]}) begin
        errCount++;
        $display("[TB] FAIL kat_round r=%0d got v=%b b=%b d=%b idx=%0d sk=%h exp sk=%h",
                 r, subkey_valid, busy, done, round_idx, subkey, expKeys[r]);
      end
      @(negedge clk);
      if (r < 31) begin
        checkCount++;
        if ({subkey_valid, done} !== 2'b00) begin
          errCount++;
          $display("[TB] FAIL kat_compute r=%0d got v=%b d=%b exp 0 0", r, subkey_valid, done);
        end
        @(negedge clk);
      end
    end
    checkCount++;
    if ({done, busy, subkey_valid} !== 3'b110) begin
      errCount++;
      $display("[TB] FAIL kat_finish got d=%b b=%b v=%b exp 1 1 0", done, busy, subkey_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkCount++;
      if ({done, busy, subkey_valid} !== 3'b000) begin
        errCount++;
        $display("[TB] FAIL kat_after_done c=%0d got d=%b b=%b v=%b exp 0 0 0",
                 c, done, busy, subkey_valid);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] mk;
    mk = {$urandom, $urandom, $urandom, $urandom};
    buildModel(mk);
    doReset();
    subkey_ready = 1'b1;
    startExpansion(mk);
    for (int r = 0; r < 32; r++) begin
      checkCount++;
      if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'(r), expKeys[r]}) begin
        errCount++;
        $display("[TB] FAIL bp_round r=%0d got v=%b idx=%0d sk=%h exp sk=%h",
                 r, subkey_valid, round_idx, subkey, expKeys[r]);
      end
      if (r == 7) begin
        subkey_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checkCount++;
          if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd7, expKeys[7]}) begin
            errCount++;
            $display("[TB] FAIL bp_stall s=%0d got v=%b idx=%0d sk=%h exp sk=%h",
                     s, subkey_valid, round_idx, subkey, expKeys[7]);
          end
        end
        subkey_ready = 1'b1;
      end
      @(negedge clk);
      if (r < 31) begin
        checkCount++;
        if (subkey_valid !== 1'b0) begin
          errCount++;
          $display("[TB] FAIL bp_gap r=%0d got v=%b exp 0", r, subkey_valid);
        end
        @(negedge clk);
      end
    end
    checkCount++;
    if (done !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL bp_done got=%b exp=1", done);
    end
  endtask

  task automatic test_start_spam();
    logic [127:0] mk, other;
    mk    = {$urandom, $urandom, $urandom, $urandom};
    other = ~mk;
    buildModel(mk);
    doReset();
    subkey_ready = 1'b1;
    startExpansion(mk);
    for (int r = 0; r < 32; r++) begin
      checkCount++;
      if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'(r), expKeys[r]}) begin
        errCount++;
        $display("[TB] FAIL spam_round r=%0d got v=%b idx=%0d sk=%h exp sk=%h",
                 r, subkey_valid, round_idx, subkey, expKeys[r]);
      end
      if (r == 3 || r == 31) begin
        start = 1'b1;
        key   = other;
      end
      @(negedge clk);
      start = 1'b0;
      if (r < 31) @(negedge clk);
    end
    checkCount++;
    if ({done, subkey_valid} !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL spam_done got d=%b v=%b exp 1 0", done, subkey_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] mkA, mkB;
    int n;
    mkA = {$urandom, $urandom, $urandom, $urandom};
    mkB = {$urandom, $urandom, $urandom, $urandom};
    doReset();
    subkey_ready = 1'b1;
    startExpansion(mkA);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkCount++;
    if (done !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL b2b_done_timeout got d=%b after %0d cycles exp 1", done, n);
    end
    start = 1'b1;
    key   = mkA;
    @(negedge clk);
    checkCount++;
    if ({subkey_valid, busy, done} !== 3'b000) begin
      errCount++;
      $display("[TB] FAIL b2b_finish_start got v=%b b=%b d=%b exp 0 0 0",
               subkey_valid, busy, done);
    end
    key = mkB;
    @(negedge clk);
    start = 1'b0;
    checkCount++;
    if ({subkey_valid, busy, round_idx, subkey} !== {2'b11, 5'd0, mkB[63:0]}) begin
      errCount++;
      $display("[TB] FAIL b2b_restart got v=%b b=%b idx=%0d sk=%h exp sk=%h",
               subkey_valid, busy, round_idx, subkey, mkB[63:0]);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] mk;
    mk = 128'h0f0e0d0c0b0a0908_0706050403020100;
    buildModel(mk);
    doReset();
    subkey_ready = 1'b1;
    startExpansion(mk);
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      @(negedge clk);
    end
    checkCount++;
    if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd12, expKeys[12]}) begin
      errCount++;
      $display("[TB] FAIL mid_round12 got v=%b idx=%0d sk=%h exp sk=%h",
               subkey_valid, round_idx, subkey, expKeys[12]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkCount++;
    if ({subkey_valid, busy, done, round_idx, subkey} !== 72'd0) begin
      errCount++;
      $display("[TB] FAIL mid_reset got v=%b b=%b d=%b idx=%0d sk=%h exp all zero",
               subkey_valid, busy, done, round_idx, subkey);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkCount++;
      if ({done, subkey_valid, busy} !== 3'b000) begin
        errCount++;
        $display("[TB] FAIL mid_quiet c=%0d got d=%b v=%b b=%b exp 0 0 0",
                 c, done, subkey_valid, busy);
      end
    end
    startExpansion(mk);
    checkCount++;
    if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd0, 64'h0706050403020100}) begin
      errCount++;
      $display("[TB] FAIL mid_restart got v=%b idx=%0d sk=%h exp 0706050403020100",
               subkey_valid, round_idx, subkey);
    end
  endtask

  task automatic test_edge_key();
    logic [127:0] mk;
    int cyc, hs;
    mk = '1;
    buildModel(mk);
    doReset();
    subkey_ready = 1'b1;
    startExpansion(mk);
    checkCount++;
    if (subkey !== 64'hffffffffffffffff) begin
      errCount++;
      $display("[TB] FAIL edge_round0 got=%h exp=ffffffffffffffff", subkey);
    end
    cyc = 2;
    hs  = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (subkey_valid === 1'b1) begin
        if (hs == 1) begin
          checkCount++;
          if (subkey !== 64'h1) begin
            errCount++;
            $display("[TB] FAIL edge_round1_carry got=%h exp=0000000000000001", subkey);
          end
        end
        checkCount++;
        if (hs >= 32 || subkey !== expKeys[hs % 32]) begin
          errCount++;
          $display("[TB] FAIL edge_round hs=%0d got=%h exp=%h", hs, subkey, expKeys[hs % 32]);
        end
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    checkCount++;
    if (hs != 32 || cyc != 65 || done !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL edge_timing got hs=%0d cyc=%0d d=%b exp hs=32 cyc=65 d=1",
               hs, cyc, done);
    end
  endtask

  task automatic test_random_ready();
    for (int t = 0; t < 3; t++) begin
      logic [127:0] mk;
      int n, doneCount, cyc;
      mk = {$urandom, $urandom, $urandom, $urandom};
      buildModel(mk);
      doReset();
      startExpansion(mk);
      n = 0;
      doneCount = 0;
      cyc = 0;
      while (doneCount == 0 && cyc < 1000) begin
        subkey_ready = ($urandom_range(0, 9) < 6);
        if (subkey_valid === 1'b1 && subkey_ready) begin
          checkCount++;
          if (n >= 32 || {round_idx, subkey} !== {5'(n), expKeys[n % 32]}) begin
            errCount++;
            $display("[TB] FAIL rand_hs t=%0d n=%0d got idx=%0d sk=%h exp sk=%h",
                     t, n, round_idx, subkey, expKeys[n % 32]);
          end
          n++;
        end
        @(negedge clk);
        cyc++;
        if (done === 1'b1) doneCount++;
      end
      checkCount++;
      if (n != 32 || doneCount != 1) begin
        errCount++;
        $display("[TB] FAIL rand_total t=%0d got hs=%0d done=%0d exp hs=32 done=1",
                 t, n, doneCount);
      end
    end
    subkey_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    subkey_ready = 1'b0;
    test_reset();
    test_known_answer();
    test_back_pressure();
    test_start_spam();
    test_back_to_back();
    test_mid_reset();
    test_edge_key();
    test_random_ready();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
